// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, redirect/kill handling.
// Optional FETCH_CTRL_PERF_EN adds perf_fetch / perf_kill event counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   output logic [31:0] req_addr,
   input  logic        req_ready,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_pc4,
   input  logic        inst_ready,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc
`ifdef FETCH_CTRL_PERF_EN
  ,output logic [31:0] perf_fetch,
   output logic [31:0] perf_kill
`endif
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic        kill, kill_nxt;
   logic        load;
   logic [31:0] redir_al;

   assign redir_al = redir_pc & ~32'h3;
   assign req_addr = pc;
   assign inst_pc4 = inst_pc + 32'd4;

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      kill_nxt   = kill;
      load       = 1'b0;
      req_valid  = 1'b0;
      inst_valid = 1'b0;
      case (state)
         S_REQ: begin
            req_valid = ~redir_valid;
            if (redir_valid)    pc_nxt    = redir_al;
            else if (req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (rsp_valid) begin
               // a same-cycle redirect kills the response outright, no kill bit needed
               state_nxt = S_REQ;
               kill_nxt  = 1'b0;
               if (redir_valid) pc_nxt = redir_al;
               else if (!kill) begin
                  load      = 1'b1;
                  pc_nxt    = pc + 32'd4;
                  state_nxt = S_OUT;
               end
            end else if (redir_valid) begin
               pc_nxt   = redir_al;
               kill_nxt = 1'b1;
            end
         end
         S_OUT: begin
            inst_valid = ~redir_valid;
            if (redir_valid) begin
               pc_nxt    = redir_al;
               state_nxt = S_REQ;
            end else if (inst_ready) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      if (rst) begin
         req_valid  = 1'b0;
         inst_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_REQ;
         pc      <= RESET_PC & ~32'h3;
         kill    <= 1'b0;
         inst    <= NOP;
         inst_pc <= 32'h0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         kill  <= kill_nxt;
         if (load) begin
            inst    <= rsp_data;
            inst_pc <= pc;
         end
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch <= 32'h0;
         perf_kill  <= 32'h0;
      end else begin
         if (inst_valid && inst_ready) perf_fetch <= perf_fetch + 32'd1;
         if ((state == S_WAIT && rsp_valid && (kill || redir_valid)) ||
             (state == S_OUT && redir_valid))
            perf_kill <= perf_kill + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table plus hand sequences.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, req_ready, rsp_valid, inst_ready, redir_valid;
   logic [31:0] rsp_data, redir_pc;
   logic        req_valid, inst_valid, req_valid1, inst_valid1;
   logic [31:0] req_addr, inst, inst_pc, inst_pc4;
   logic [31:0] req_addr1, inst1, inst_pc1, inst_pc41;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] perf_fetch, perf_kill, perf_fetch1, perf_kill1;
`endif

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
      .inst_ready(inst_ready), .redir_valid(redir_valid), .redir_pc(redir_pc)
`ifdef FETCH_CTRL_PERF_EN
     ,.perf_fetch(perf_fetch), .perf_kill(perf_kill)
`endif
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr1),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .inst_valid(inst_valid1), .inst(inst1), .inst_pc(inst_pc1), .inst_pc4(inst_pc41),
      .inst_ready(inst_ready), .redir_valid(redir_valid), .redir_pc(redir_pc)
`ifdef FETCH_CTRL_PERF_EN
     ,.perf_fetch(perf_fetch1), .perf_kill(perf_kill1)
`endif
   );

   typedef struct {
      logic        rst, rr, rv;
      logic [31:0] rd;
      logic        ir, xv;
      logic [31:0] xp;
      logic        ck, e_rqv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst, e_ipc;
   } vec_t;

   vec_t tbl[$];
   int   errs = 0;
   int   checks = 0;

   function automatic vec_t mk(logic r, logic rr, logic rv, logic [31:0] rd, logic ir,
                               logic xv, logic [31:0] xp, logic ck, logic rqv,
                               logic [31:0] addr, logic iv, logic [31:0] ins, logic [31:0] ipc);
      vec_t v;
      v.rst = r; v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xp = xp;
      v.ck = ck; v.e_rqv = rqv; v.e_addr = addr; v.e_iv = iv; v.e_inst = ins; v.e_ipc = ipc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                        input logic ir, input logic xv, input logic [31:0] xp);
      rst = r; req_ready = rr; rsp_valid = rv; rsp_data = rd;
      inst_ready = ir; redir_valid = xv; redir_pc = xp;
   endtask

   initial begin
      int n;
      drive(1, 0, 0, 0, 0, 0, 0);

      // reset
      tbl.push_back(mk(1,0,0,0,0,0,0, 0, 0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,NOP,0));
      // basic fetch of 0x00500093
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,0,0,NOP,0));
      tbl.push_back(mk(0,0,1,32'h00500093,0,0,0, 1, 0,0,0,NOP,0));
      tbl.push_back(mk(0,0,0,0,1,0,0, 1, 0,4,1,32'h00500093,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 1, 0,4,0,32'h00500093,0));
      // memory stall: request held at 0
      for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0,0,0, 1, 1,0,0,NOP,0));
      // redirect during wait, stale response 2 cycles later
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,0,0,NOP,0));
      tbl.push_back(mk(0,0,0,0,0,1,32'h100, 1, 0,0,0,NOP,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 1, 0,32'h100,0,NOP,0));
      tbl.push_back(mk(0,0,1,32'hDEADBEEF,0,0,0, 1, 0,32'h100,0,NOP,0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h100,0,NOP,0));
      // decode stall then redirect to misaligned 0x203
      tbl.push_back(mk(0,0,1,32'h11111111,0,0,0, 1, 0,32'h100,0,NOP,0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0,0,0,0,0,0,0, 1, 0,32'h104,1,32'h11111111,32'h100));
      tbl.push_back(mk(0,0,0,0,1,1,32'h203, 1, 0,32'h104,0,32'h11111111,32'h100));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h200,0,32'h11111111,32'h100));
      // redirect same cycle as response, then redirect in S_REQ
      tbl.push_back(mk(0,0,1,32'h22222222,0,1,32'h300, 1, 0,32'h200,0,32'h11111111,32'h100));
      tbl.push_back(mk(0,0,0,0,0,1,32'h404, 1, 0,32'h300,0,32'h11111111,32'h100));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h404,0,32'h11111111,32'h100));
      tbl.push_back(mk(0,0,1,32'h33333333,0,0,0, 1, 0,32'h404,0,32'h11111111,32'h100));
      // stray responses outside S_WAIT are ignored
      tbl.push_back(mk(0,0,1,32'h44444444,1,0,0, 1, 0,32'h408,1,32'h33333333,32'h404));
      tbl.push_back(mk(0,0,1,32'h55555555,0,0,0, 1, 1,32'h408,0,32'h33333333,32'h404));
      // reset in S_WAIT overrides redirect; late response ignored
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h408,0,32'h33333333,32'h404));
      tbl.push_back(mk(1,0,0,0,0,1,32'h500, 1, 0,32'h408,0,32'h33333333,32'h404));
      tbl.push_back(mk(0,0,1,32'h66666666,0,0,0, 1, 1,0,0,NOP,0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1, 1,0,0,NOP,0));

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].rst, tbl[i].rr, tbl[i].rv, tbl[i].rd, tbl[i].ir, tbl[i].xv, tbl[i].xp);
         #1;
         chk($sformatf("v%0d req_valid", i), {31'b0, req_valid}, {31'b0, tbl[i].e_rqv});
         chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
         if (tbl[i].ck) begin
            chk($sformatf("v%0d req_addr", i), req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d inst", i), inst, tbl[i].e_inst);
            chk($sformatf("v%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
            chk($sformatf("v%0d inst_pc4", i), inst_pc4, tbl[i].e_ipc + 32'd4);
         end
      end
`ifdef FETCH_CTRL_PERF_EN
      @(negedge clk); #1;
      chk("perf_fetch after reset", perf_fetch, 0);
      chk("perf_kill after reset", perf_kill, 0);
`endif

      // throughput: everything ready, one instruction every 3 cycles
      @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 1, NOP, 1, 0, 0);
      n = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (inst_valid && inst_ready) begin
            chk($sformatf("thru inst_pc %0d", n), inst_pc, 32'(n) * 32'd4);
            n++;
         end
         @(negedge clk);
      end
      chk("thru count", 32'(n), 4);
`ifdef FETCH_CTRL_PERF_EN
      #1;
      chk("thru perf_fetch", perf_fetch, 4);
      chk("thru perf_kill", perf_kill, 0);
`endif

      // wraparound on the RESET_PC=0xFFFFFFFC instance
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0);
      #1;
      chk("wrap req_valid", {31'b0, req_valid1}, 1);
      chk("wrap req_addr", req_addr1, 32'hFFFF_FFFC);
      @(negedge clk); drive(0, 0, 1, 32'h00100073, 0, 0, 0);
      @(negedge clk); drive(0, 0, 0, 0, 1, 0, 0);
      #1;
      chk("wrap inst_valid", {31'b0, inst_valid1}, 1);
      chk("wrap inst", inst1, 32'h00100073);
      chk("wrap inst_pc", inst_pc1, 32'hFFFF_FFFC);
      chk("wrap inst_pc4", inst_pc41, 0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("wrap next req_valid", {31'b0, req_valid1}, 1);
      chk("wrap next req_addr", req_addr1, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
